// File: rtl/deser8.sv
// deser8: 1-to-8 serial-to-parallel deserializer with valid/ready handshake on both sides.
// Bit order is LSB first by default; define DESER8_MSB_FIRST_EN for MSB first.
module deser8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  output logic       din_ready,
  input  logic       clear,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic [2:0] sel,
  output logic       busy
);

  // state   | meaning
  // IDLE    | sel=0, no bits of a frame held
  // COLLECT | 1-7 bits of the current frame held in the shadow register
  // HOLD    | completed byte on dout, waiting for the consumer
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] dout_q, dout_d;

  logic       accept;
  logic [2:0] slot;
  logic [7:0] shadow_wr;

  assign dout_valid = (state_q == HOLD);
  assign din_ready  = ~dout_valid;
  assign busy       = (state_q == COLLECT);
  assign sel        = sel_q;
  assign dout       = dout_q;

  assign accept = din_valid & din_ready & ~clear;

`ifdef DESER8_MSB_FIRST_EN
  assign slot = 3'd7 - sel_q;
`else
  assign slot = sel_q;
`endif

  // Shadow contents with the incoming bit written into its slot.
  always_comb begin
    shadow_wr       = shadow_q;
    shadow_wr[slot] = din;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    if (clear) begin
      state_d  = IDLE;
      sel_d    = 3'd0;
      shadow_d = 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d  = COLLECT;
            sel_d    = 3'd1;
            shadow_d = shadow_wr;
          end
        end
        COLLECT: begin
          if (accept) begin
            if (sel_q == 3'd7) begin
              state_d  = HOLD;
              sel_d    = 3'd0;
              shadow_d = 8'h00;
              dout_d   = shadow_wr;
            end else begin
              sel_d    = sel_q + 3'd1;
              shadow_d = shadow_wr;
            end
          end
        end
        HOLD: begin
          if (dout_ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d  = IDLE;
          sel_d    = 3'd0;
          shadow_d = 8'h00;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 3'd0;
      shadow_q <= 8'h00;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: tb/tb_deser8.sv
// Testbench for deser8: directed scenarios plus randomized traffic against a
// frame-level reference model (bit count, byte accumulator, held byte).
module tb_deser8;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       din_ready;
  logic       clear;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [2:0] sel;
  logic       busy;

  deser8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .clear     (clear),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         m_n;
  int         m_acc;
  logic       m_valid;
  logic [7:0] m_dout;

`ifdef DESER8_MSB_FIRST_EN
  localparam bit MSB_FIRST = 1'b1;
`else
  localparam bit MSB_FIRST = 1'b0;
`endif
  localparam logic [7:0] EXP_ALT  = MSB_FIRST ? 8'h55 : 8'hAA;
  localparam logic [7:0] EXP_GAPS = MSB_FIRST ? 8'hCB : 8'hD3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n     = 0;
    m_acc   = 0;
    m_valid = 1'b0;
    m_dout  = 8'h00;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".dout"},       {24'd0, dout},      {24'd0, m_dout});
    check({tag, ".dout_valid"}, {31'd0, dout_valid}, {31'd0, m_valid});
    check({tag, ".din_ready"},  {31'd0, din_ready},  {31'd0, ~m_valid});
    check({tag, ".sel"},        {29'd0, sel},        m_n);
    check({tag, ".busy"},       {31'd0, busy},       {31'd0, (m_n != 0)});
  endtask

  // One clock cycle: apply inputs, let the edge happen, advance the model, compare.
  task automatic cyc(input logic v, input logic b, input logic dr, input logic clr);
    int pos;
    din_valid  = v;
    din        = b;
    dout_ready = dr;
    clear      = clr;
    @(posedge clk);
    #1;
    if (clr) begin
      m_n   = 0;
      m_acc = 0;
      m_valid = 1'b0;
    end else if (m_valid) begin
      if (dr) m_valid = 1'b0;
    end else if (v) begin
      pos = MSB_FIRST ? (7 - m_n) : m_n;
      m_acc = m_acc + (int'(b) << pos);
      m_n++;
      if (m_n == 8) begin
        m_dout  = m_acc[7:0];
        m_valid = 1'b1;
        m_n     = 0;
        m_acc   = 0;
      end
    end
    check_outputs("cyc");
  endtask

  task automatic send_byte(input logic [7:0] bits, input int gap);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, bits[k], 1'b0, 1'b0);
      if (k < 7)
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] pat;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; clear = 1'b0; dout_ready = 1'b0;
    model_reset();
    #3;
    check_outputs("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_outputs("reset_release");

    // Reset mid-frame after 4 bits, observed without a clock edge
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_sel4", {29'd0, sel}, 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Alternating frame 0,1,0,1,... with no consumer
    pat = 8'b1010_1010;
    send_byte(pat, 0);
    check("alt_dout", {24'd0, dout}, {24'd0, EXP_ALT});
    check("alt_valid", {31'd0, dout_valid}, 32'd1);
    check("alt_sel", {29'd0, sel}, 32'd0);
    check("alt_busy", {31'd0, busy}, 32'd0);

    // Backpressure: offered bits are refused while the byte is held
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_ready", {31'd0, din_ready}, 32'd0);
    check("bp_dout", {24'd0, dout}, {24'd0, EXP_ALT});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("bp_consumed", {31'd0, dout_valid}, 32'd0);
    check("bp_ready_back", {31'd0, din_ready}, 32'd1);
    check("bp_dout_hold", {24'd0, dout}, {24'd0, EXP_ALT});

    // Gaps of two idle cycles between bits 1,1,0,0,1,0,1,1
    pat = 8'b1101_0011;
    send_byte(pat, 2);
    check("gap_dout", {24'd0, dout}, {24'd0, EXP_GAPS});
    cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // Clear after three bits, coincident with an offered bit
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    check("clr_sel", {29'd0, sel}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_dout", {24'd0, dout}, {24'd0, EXP_GAPS});
    send_byte(8'hFF, 0);
    check("ff_dout", {24'd0, dout}, 32'hFF);

    // Clear beats a simultaneous consume
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("clr_consume", {31'd0, dout_valid}, 32'd0);

    // Randomized traffic, with one asynchronous reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rand_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      cyc(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/deser8.md
DESER8 -- requirements
Module: deser8

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port din, input, 1 bit: serial data bit.
REQ-004 The block SHALL have port din_valid, input, 1 bit: din holds a bit to transfer this cycle.
REQ-005 The block SHALL have port din_ready, output, 1 bit: block accepts din this cycle.
REQ-006 The block SHALL have port clear, input, 1 bit: synchronous abort of the frame in progress.
REQ-007 The block SHALL have port dout, output, 8 bits: last completed parallel byte.
REQ-008 The block SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed byte.
REQ-009 The block SHALL have port dout_ready, input, 1 bit: consumer takes dout this cycle.
REQ-010 The block SHALL have port sel, output, 3 bits: demux select; the slot the next accepted bit is written to.
REQ-011 The block SHALL have port busy, output, 1 bit: at least one bit of the current frame has been accepted.

Function
REQ-012 The block SHALL act as the demultiplexing counterpart of an 8:1 select: accepted bit k of a frame (k=0..7) is written to slot sel=k of an internal 8-bit shadow register.
REQ-013 A bit SHALL be accepted on a rising edge where din_valid=1 and din_ready=1 and clear=0; sel then increments by 1 (modulo 8).
REQ-014 din_ready SHALL equal NOT dout_valid (combinational); no bit is accepted while an unconsumed byte is held.
REQ-015 The state machine SHALL have states IDLE (sel=0, no bits), COLLECT (1-7 bits held), HOLD (dout_valid=1).
REQ-016 Transitions: IDLE->COLLECT on accept; COLLECT->COLLECT on accept with sel<7; COLLECT->HOLD on accept with sel=7; HOLD->IDLE on dout_valid&dout_ready; any state->IDLE on clear.
REQ-017 On the 8th accept, dout SHALL load the shadow contents including the 8th bit, and dout_valid SHALL be 1 from that same edge (latency: one edge after the 8th bit).
REQ-018 dout SHALL change only on frame completion and SHALL hold its value through IDLE, COLLECT, clear and consumption.
REQ-019 dout_valid SHALL stay 1 until an edge with dout_ready=1, then go 0 on that edge; dout_ready while dout_valid=0 SHALL have no effect.
REQ-020 busy SHALL be 1 exactly in COLLECT.
REQ-021 clear=1 SHALL, on the next edge, force sel=0, discard the shadow contents, and drop dout_valid; clear takes priority over a simultaneous accept (bit discarded) and a simultaneous consume.
REQ-022 Gaps (din_valid=0) of any length within a frame SHALL not affect the assembled byte.
REQ-023 Unused shadow bits SHALL not appear on dout; a partial frame never reaches dout.

Reset
REQ-024 While rst_n=0 the block SHALL immediately, without clock, force: state IDLE, sel=000, shadow=00, dout=8'h00, dout_valid=0, busy=0, din_ready=1.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first accepted bit after release is bit 0 of a new frame.
REQ-026 Reset release SHALL take effect on the first rising edge with rst_n=1.

Configuration
REQ-027 Macro DESER8_MSB_FIRST_EN SHALL select bit order.
REQ-028 Without DESER8_MSB_FIRST_EN: bit k of a frame lands in dout[k] (LSB first).
REQ-029 With DESER8_MSB_FIRST_EN: bit k lands in dout[7-k] (MSB first); sel still counts 0..7 and all handshake and timing are unchanged.

Verification
REQ-030 Reset: rst_n=0 mid-frame after 4 bits -> dout=00, dout_valid=0, sel=000, busy=0, din_ready=1 with no clock edge.
REQ-031 Frame LSB-first: bits 0,1,0,1,0,1,0,1 on consecutive cycles, dout_ready=0 -> dout=8'hAA, dout_valid=1 after 8th edge, sel=000, busy=0.
REQ-032 Backpressure: after REQ-031 hold din_valid=1, dout_ready=0 for 5 cycles -> din_ready=0, sel=000, dout=AA stable; dout_ready=1 for one edge -> dout_valid=0, din_ready=1.
REQ-033 Gaps: bits 1,1,0,0,1,0,1,1 with din_valid=0 for 2 cycles between each -> dout=8'hD3; sel steps 0..7 only on accepts.
REQ-034 Clear: 3 bits of 1 then clear=1 with din_valid=1 on same edge -> sel=000, busy=0, dout unchanged; then eight 1s -> dout=8'hFF.
REQ-035 With DESER8_MSB_FIRST_EN defined: stimulus of REQ-031 -> dout=8'h55, same dout_valid timing.
